// File: rtl/mc_control_unit_if.sv
// Control/handshake bundle between the multi-cycle control unit (master)
// and the instruction memory / datapath side (slave).
interface mc_control_unit_if;
  logic [31:0] instrCode;
  logic        fetchReady;
  logic        ready;
  logic        fetchReq;
  logic        PCEn;
  logic        regFileWe;
  logic [3:0]  aluControl;
  logic        aluSrcMuxSel;
  logic        busWe;
  logic [2:0]  RFWDSrcMuxSel;
  logic        branch;
  logic        jal;
  logic        jalr;
  logic        transfer;
  logic        trap;
  logic [1:0]  trapCause;

  modport master (
    input  instrCode, fetchReady, ready,
    output fetchReq, PCEn, regFileWe, aluControl, aluSrcMuxSel, busWe,
           RFWDSrcMuxSel, branch, jal, jalr, transfer, trap, trapCause
  );

  modport slave (
    output instrCode, fetchReady, ready,
    input  fetchReq, PCEn, regFileWe, aluControl, aluSrcMuxSel, busWe,
           RFWDSrcMuxSel, branch, jal, jalr, transfer, trap, trapCause
  );
endinterface

// File: rtl/mc_control_unit.sv
// Multi-cycle RV32I control FSM with handshaked fetch/bus access and illegal-opcode trap.
// Define MC_CU_BUS_TIMEOUT_EN to add a handshake watchdog that traps stalled transfers.
module mc_control_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned TIMEOUT_W      = $clog2(TIMEOUT_CYCLES + 1)
) (
  input logic               clk,
  input logic               reset,
  mc_control_unit_if.master bus
);

  typedef enum logic [3:0] {
    FETCH, DECODE, R_EXE, I_EXE, B_EXE, LU_EXE, AU_EXE, J_EXE,
    JL_EXE, S_EXE, S_MEM, L_EXE, L_MEM, L_WB, TRAP
  } state_t;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SRAI = 4'b1101;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_L     = 7'b0000011;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'd0;
  localparam logic [1:0] CAUSE_FETCH   = 2'd1;
  localparam logic [1:0] CAUSE_LOAD    = 2'd2;
  localparam logic [1:0] CAUSE_STORE   = 2'd3;

  state_t     state_q, state_d;
  logic [1:0] cause_q, cause_d;
  logic       timeout;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       instr30;

  assign opcode  = bus.instrCode[6:0];
  assign funct3  = bus.instrCode[14:12];
  assign instr30 = bus.instrCode[30];

  // Register/immediate fields are decoded by the datapath, not here.
  logic unused_bits;
  assign unused_bits = ^{bus.instrCode[31], bus.instrCode[29:15],
                         bus.instrCode[11:7], (TIMEOUT_W != 0)};

`ifdef MC_CU_BUS_TIMEOUT_EN
  logic                 hs_low;
  logic [TIMEOUT_W-1:0] wd_cnt;

  assign hs_low = ((state_q == FETCH) && !bus.fetchReady) ||
                  (((state_q == S_MEM) || (state_q == L_MEM)) && !bus.ready);

  // Fires on the TIMEOUT_CYCLES-th consecutive stalled cycle of a wait state.
  assign timeout = hs_low && (wd_cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   wd_cnt <= '0;
    else if (state_d != state_q) wd_cnt <= '0;
    else if (hs_low)             wd_cnt <= wd_cnt + TIMEOUT_W'(1);
  end
`else
  assign timeout = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      cause_q <= CAUSE_ILLEGAL;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    unique case (state_q)
      FETCH: begin
        if (bus.fetchReady) state_d = DECODE;
        else if (timeout) begin
          state_d = TRAP;
          cause_d = CAUSE_FETCH;
        end
      end
      DECODE: begin
        unique case (opcode)
          OP_R:     state_d = R_EXE;
          OP_I:     state_d = I_EXE;
          OP_B:     state_d = B_EXE;
          OP_LUI:   state_d = LU_EXE;
          OP_AUIPC: state_d = AU_EXE;
          OP_JAL:   state_d = J_EXE;
          OP_JALR:  state_d = JL_EXE;
          OP_S:     state_d = S_EXE;
          OP_L:     state_d = L_EXE;
          default: begin
            state_d = TRAP;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_EXE: state_d = S_MEM;
      S_MEM: begin
        if (bus.ready) state_d = FETCH;
        else if (timeout) begin
          state_d = TRAP;
          cause_d = CAUSE_STORE;
        end
      end
      L_EXE: state_d = L_MEM;
      L_MEM: begin
        if (bus.ready) state_d = L_WB;
        else if (timeout) begin
          state_d = TRAP;
          cause_d = CAUSE_LOAD;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    bus.fetchReq      = 1'b0;
    bus.PCEn          = 1'b0;
    bus.regFileWe     = 1'b0;
    bus.aluControl    = ALU_ADD;
    bus.aluSrcMuxSel  = 1'b0;
    bus.busWe         = 1'b0;
    bus.RFWDSrcMuxSel = 3'd0;
    bus.branch        = 1'b0;
    bus.jal           = 1'b0;
    bus.jalr          = 1'b0;
    bus.transfer      = 1'b0;
    bus.trap          = 1'b0;
    bus.trapCause     = 2'd0;
    unique case (state_q)
      FETCH: begin
        bus.fetchReq = 1'b1;
        bus.PCEn     = bus.fetchReady;
      end
      R_EXE: begin
        bus.regFileWe  = 1'b1;
        bus.aluControl = {instr30, funct3};
      end
      I_EXE: begin
        bus.regFileWe    = 1'b1;
        bus.aluSrcMuxSel = 1'b1;
        // Only SRAI carries bit 30 into the ALU; elsewhere it is immediate data.
        bus.aluControl   = ({instr30, funct3} == ALU_SRAI) ? ALU_SRAI : {1'b0, funct3};
      end
      B_EXE: begin
        bus.branch     = 1'b1;
        bus.aluControl = {1'b0, funct3};
      end
      LU_EXE: begin
        bus.regFileWe     = 1'b1;
        bus.RFWDSrcMuxSel = 3'd2;
      end
      AU_EXE: begin
        bus.regFileWe     = 1'b1;
        bus.RFWDSrcMuxSel = 3'd3;
      end
      J_EXE: begin
        bus.regFileWe     = 1'b1;
        bus.RFWDSrcMuxSel = 3'd4;
        bus.jal           = 1'b1;
      end
      JL_EXE: begin
        bus.regFileWe     = 1'b1;
        bus.RFWDSrcMuxSel = 3'd4;
        bus.jal           = 1'b1;
        bus.jalr          = 1'b1;
      end
      S_EXE: bus.aluSrcMuxSel = 1'b1;
      S_MEM: begin
        bus.aluSrcMuxSel = 1'b1;
        bus.busWe        = 1'b1;
        bus.transfer     = 1'b1;
      end
      L_EXE: begin
        bus.aluSrcMuxSel  = 1'b1;
        bus.RFWDSrcMuxSel = 3'd1;
      end
      L_MEM: begin
        bus.aluSrcMuxSel  = 1'b1;
        bus.RFWDSrcMuxSel = 3'd1;
        bus.transfer      = 1'b1;
      end
      L_WB: begin
        bus.regFileWe     = 1'b1;
        bus.aluSrcMuxSel  = 1'b1;
        bus.RFWDSrcMuxSel = 3'd1;
      end
      TRAP: begin
        bus.trap      = 1'b1;
        bus.trapCause = cause_q;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/mc_control_unit.md
# mc_control_unit

Multi-cycle RV32I control FSM with handshaked instruction fetch, handshaked data-bus access, illegal-opcode trapping and an optional bus-timeout watchdog. Sits between the instruction memory/PC unit and the datapath (register file, ALU, RFWD mux, APB-style data bus master). It drives all datapath enables and selects one instruction at a time.

## Interface
- TIMEOUT_CYCLES, 16: stall cycles tolerated on any handshake before a timeout trap (1..255).
- TIMEOUT_W, $clog2(TIMEOUT_CYCLES+1): watchdog counter width. Derived; do not override.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- instrCode  in  32  current instruction, stable from DECODE until return to FETCH.
- fetchReady  in  1  instruction memory has data.
- ready  in  1  data-bus transfer complete.
- fetchReq  out  1  instruction fetch request.
- PCEn  out  1  PC register load.
- regFileWe  out  1  register file write.
- aluControl  out  4  ALU operation; `ADD` = 4'b0000.
- aluSrcMuxSel  out  1  0 = rs2, 1 = immediate.
- busWe  out  1  bus write.
- RFWDSrcMuxSel  out  3  0 ALU, 1 bus rdata, 2 LUI imm, 3 AUIPC, 4 PC+4.
- branch, jal, jalr  out  1 each  PC-next selects.
- transfer  out  1  bus transfer request.
- trap  out  1  one-cycle trap strobe; PC unit redirects to trap vector.
- trapCause  out  2  0 illegal opcode, 1 fetch timeout, 2 load timeout, 3 store timeout.

## Operation
- States: FETCH, DECODE, R_EXE, I_EXE, B_EXE, LU_EXE, AU_EXE, J_EXE, JL_EXE, S_EXE, S_MEM, L_EXE, L_MEM, L_WB, TRAP. Reset state FETCH.
- All outputs are combinational from the state (and instrCode/handshake inputs). Default every output is 0 and aluControl = ADD.
- FETCH: fetchReq=1, PCEn=fetchReady. If fetchReady, go to DECODE; otherwise stay.
- DECODE: all outputs 0. Branch on opcode:
  - 0110011 → R_EXE; 0010011 → I_EXE; 1100011 → B_EXE.
  - 0110111 → LU_EXE; 0010111 → AU_EXE; 1101111 → J_EXE; 1100111 → JL_EXE.
  - 0100011 → S_EXE; 0000011 → L_EXE.
  - Any other opcode → TRAP with cause 0.
- R_EXE: regFileWe=1; aluControl={instr[30],funct3}.
- I_EXE: regFileWe=1, aluSrcMuxSel=1; aluControl=4'b1101 when {instr[30],funct3}==4'b1101 (SRAI), else {1'b0,funct3}.
- B_EXE: branch=1; aluControl={1'b0,funct3}. Immediate bit 30 never reaches the ALU.
- LU_EXE: regFileWe=1, RFWD=2. AU_EXE: regFileWe=1, RFWD=3.
- J_EXE: regFileWe=1, RFWD=4, jal=1. JL_EXE: same as J_EXE plus jalr=1.
- S_EXE: aluSrcMuxSel=1. S_MEM: aluSrcMuxSel=1, busWe=1, transfer=1; exit on ready.
- L_EXE: aluSrcMuxSel=1, RFWD=1. L_MEM: L_EXE outputs plus transfer=1; exit on ready to L_WB.
- L_WB: regFileWe=1, aluSrcMuxSel=1, RFWD=1.
- All *_EXE states except S_EXE and L_EXE return to FETCH. S_EXE → S_MEM; L_EXE → L_MEM.
- TRAP: trap=1, trapCause held from the entry cause, all other outputs 0; next state FETCH. The cause register resets to 0.

## Timing
- Latency with zero-wait handshakes: R/I/B/LU/AU/J/JL take 3 cycles; store takes 4; load takes 5.
- Each stall cycle (fetchReady or ready low) adds one cycle. The control outputs stay constant while stalled.
- regFileWe is asserted for exactly one cycle per writing instruction. Bus writes commit on the S_MEM cycle where ready=1.
- Reset mid-operation: the next edge after release starts in FETCH. No bus write or register write is issued while reset is high.
- An illegal opcode produces trap exactly 1 cycle after DECODE. PCEn is not asserted for that instruction beyond its fetch.

## Configuration
- MC_CU_BUS_TIMEOUT_EN defined:
  - The watchdog counter clears on every state change and increments each cycle spent in FETCH, S_MEM or L_MEM with the handshake low.
  - When the count reaches TIMEOUT_CYCLES with the handshake still low, the next state is TRAP with cause 1, 3 or 2 respectively.
  - If the handshake goes high on the same cycle the count is reached, it completes normally.
- MC_CU_BUS_TIMEOUT_EN undefined: no counter, waits are unbounded, and causes 1–3 are never produced.

## Test plan
- add x3,x1,x2 (0x002081B3), zero-wait: FETCH/DECODE/R_EXE, then regFileWe=1 for 1 cycle with aluControl=0000; back in FETCH at cycle 3.
- srai (instr[30]=1, funct3=101, opcode 0010011): aluControl=1101. slli: aluControl=0001. beq with imm bit 30 set: aluControl=0000.
- lw with ready low for 3 cycles: L_MEM held 4 cycles with transfer=1; regFileWe in L_WB only; total 8 cycles.
- Opcode 0x7F: trap=1 and trapCause=0 in the cycle after DECODE, then FETCH; no regFileWe or busWe.
- With the macro and TIMEOUT_CYCLES=4, a store with ready held low: after 4 stall cycles, trap with trapCause=3. Without the macro: stays in S_MEM indefinitely.
- Assert reset during S_MEM: busWe drops immediately; after release the state is FETCH with fetchReq=1.
